logic_gate_unit: RTL and testbench
==================================

// Module: logic_gate_unit
// PURPOSE
//  Parametrised, registered successor to the single-bit combinational gate block.
//  Applies one of eight bitwise gate ops to WIDTH-bit operands A and B behind a
//  valid/ready handshake, with a one-beat output register.
//  Adds a packet accumulate mode that folds a stream of A words through the selected op.
//  Sits between a stream source and any stream sink in the lab datapath.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=1)
//  CNT_W   4  width of the beat counter reported with each result (>=1)
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_last    in   1      last beat of packet (used only in accumulate mode)
//  op         in   3      0 AND, 1 OR, 2 NOT A, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS A
//  acc_mode   in   1      0 = per-beat mode, 1 = accumulate mode
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B (first beat of packet only in accumulate mode)
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts result
//  Y          out  WIDTH  result
//  out_count  out  CNT_W  beats folded into Y (per-beat mode: always 1)
//  out_zero   out  1      Y == 0
//  out_ones   out  1      Y == all ones
// BEHAVIOUR
//  - Reset (async assert, sync deassert OK): out_valid=0, Y=0, out_count=0,
//    out_zero=0, out_ones=0, in_pkt=0, accumulator=0, beat counter=0.
//  - in_ready = !out_valid || out_ready (combinational). Beat accepted when in_valid && in_ready.
//  - Result accepted when out_valid && out_ready; Y and flags hold while out_valid && !out_ready.
//  - gate(x,y,op): bitwise per op table. NOT A gives ~x; PASS A gives x.
//  - Per-beat mode: accepted beat -> next edge: Y=gate(A,B,op), out_count=1,
//    out_valid=1, flags updated. Latency 1 cycle. Full throughput when out_ready=1.
//    in_last is ignored.
//  - Accumulate mode uses two states, IDLE (in_pkt=0) and PKT (in_pkt=1).
//  - IDLE, beat accepted:
//      acc_mode and op are latched for the packet; acc=gate(A,B,op); cnt=1.
//      If in_last=1, emit Y=acc with out_count=1 and stay in IDLE.
//      Otherwise go to PKT.
//  - PKT, beat accepted:
//      acc=gate(acc,A,op_latched); cnt=cnt+1, saturating at 2^CNT_W-1. B is ignored.
//      If in_last=1, emit Y=new acc and out_count=new cnt, then go to IDLE.
//      A non-last beat produces no output; out_valid is unchanged.
//  - acc_mode and op inputs are ignored mid-packet; the latched values are used.
//  - Emit and accept in the same cycle: the new result overwrites Y, out_valid stays 1,
//    no bubble.
//  - A reset mid-packet discards the partial accumulation; the block returns to IDLE.
// TESTING (WIDTH=8, CNT_W=4)
//  1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, Y=0, in_ready=1 after release.
//  2. Per-beat sweep: A=8'hF0, B=8'hCC, op=0..7 back-to-back, out_ready=1 ->
//     Y = C0, FC, 0F, 3F, 03, 3C, C3, F0 on consecutive cycles; out_count=1 each.
//  3. Backpressure: out_ready=0 after first result -> in_ready=0; Y stays 8'hC0 until
//     out_ready=1, then the next result follows with no lost or duplicated beats.
//  4. Accumulate XOR: beats (A=01,B=02), then A=04, A=08 with in_last on the third ->
//     one output: Y=8'h0F, out_count=3, out_zero=0.
//  5. Accumulate AND, single beat: A=FF, B=FF, in_last=1 -> Y=FF, out_ones=1, out_count=1.
//     Then 20 beats of A=FF with op=0 -> out_count=15 (saturated).
//  6. Reset mid-packet after 2 beats, then a 1-beat OR packet (A=11, B=22, in_last=1) ->
//     Y=8'h33, out_count=1.

Source files
------------

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise gate unit with valid/ready handshake and packet fold mode
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_last   input beat handshake, packet end marker
//   op, acc_mode, A, B          gate select, accumulate enable, operands
//   out_valid/out_ready         result handshake
//   Y, out_count                result, beats folded into it
//   out_zero, out_ones          Y all zeros / all ones
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic             out_ones
);
    typedef enum logic {IDLE, PKT} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc, g, gx, gy;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0] op_l, g_op;
    logic accept, emit, in_pkt;

    function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] o);
        case (o)
            3'd0: gate = x & y;
            3'd1: gate = x | y;
            3'd2: gate = ~x;
            3'd3: gate = ~(x & y);
            3'd4: gate = ~(x | y);
            3'd5: gate = x ^ y;
            3'd6: gate = ~(x ^ y);
            default: gate = x;
        endcase
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept = in_valid && in_ready;
    assign in_pkt = state == PKT;

    // Mid-packet the accumulator takes the place of A and A the place of B.
    always_comb begin
        gx = in_pkt ? acc : A;
        gy = in_pkt ? A : B;
        g_op = in_pkt ? op_l : op;
        g = gate(gx, gy, g_op);
        cnt_nx = !in_pkt ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
        emit = accept && (in_pkt ? in_last : (!acc_mode || in_last));
        state_nx = !accept ? state : (in_pkt ? (in_last ? IDLE : PKT) : ((acc_mode && !in_last) ? PKT : IDLE));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            op_l <= '0;
            out_valid <= 1'b0;
            Y <= '0;
            out_count <= '0;
            out_zero <= 1'b0;
            out_ones <= 1'b0;
        end else begin
            if (accept) begin
                acc <= g;
                cnt <= cnt_nx;
                if (!in_pkt) op_l <= op;
            end
            if (emit) begin
                out_valid <= 1'b1;
                Y <= g;
                out_count <= cnt_nx;
                out_zero <= g == '0;
                out_ones <= &g;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_logic_gate_unit.sv
// tb_logic_gate_unit: randomized scoreboard bench for logic_gate_unit against a packet-level fold model
module tb_logic_gate_unit;
    localparam int W = 8;
    localparam int CW = 4;
    logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, acc_mode = 0, out_ready = 1;
    logic [2:0] op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic in_ready, out_valid, out_zero, out_ones;
    logic [W-1:0] y;
    logic [CW-1:0] out_count;
    int checks = 0, failures = 0, rdy_mode = 1;
    typedef struct packed {logic [W-1:0] y; logic [CW-1:0] c;} exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    logic [W-1:0] pa[0:31];

    logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op(op), .acc_mode(acc_mode), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
        .Y(y), .out_count(out_count), .out_zero(out_zero), .out_ones(out_ones));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gate_ref(input logic [W-1:0] x, input logic [W-1:0] z, input logic [2:0] o);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~x;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return x ^ z;
            3'd6: return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    always @(negedge clk)
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got Y=%0h expected no output", y);
            end else begin
                mon_e = sbq.pop_front();
                check("Y", 32'(y), 32'(mon_e.y));
                check("out_count", 32'(out_count), 32'(mon_e.c));
                check("out_zero", 32'(out_zero), 32'(mon_e.y == 0));
                check("out_ones", 32'(out_ones), 32'(mon_e.y == '1));
            end
        end

    task automatic drive(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic [2:0] op_, input logic mode_, input logic last_);
        int t = 0;
        a = a_; b = b_; op = op_; acc_mode = mode_; in_last = last_; in_valid = 1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout got in_ready=0 expected 1 within 200 cycles");
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic per_beat(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic [2:0] op_);
        sbq.push_back({gate_ref(a_, b_, op_), CW'(1)});
        drive(a_, b_, op_, 0, 1'($urandom));
    endtask

    // Whole packet folded from pa[0..n-1]; B and op matter only on the first beat.
    task automatic pkt(input logic [2:0] op_, input logic [W-1:0] b_, input int n);
        logic [W-1:0] r = gate_ref(pa[0], b_, op_);
        for (int i = 1; i < n; i++) r = gate_ref(r, pa[i], op_);
        sbq.push_back({r, CW'(n > 15 ? 15 : n)});
        for (int i = 0; i < n; i++)
            drive(pa[i], i == 0 ? b_ : W'($urandom), i == 0 ? op_ : 3'($urandom), i == 0 ? 1'b1 : 1'($urandom), i == n - 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        rdy_mode = 1;
        while (sbq.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_size", 32'(sbq.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 1;
        a = 8'h5A;
        b = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_Y", 32'(y), 0);
            check("rst_out_count", 32'(out_count), 0);
        end
        check("rst_out_zero", 32'(out_zero), 0);
        check("rst_out_ones", 32'(out_ones), 0);
        @(posedge clk);
        #1;
        in_valid = 0;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) per_beat(8'hF0, 8'hCC, 3'(i));
        idle();
        wait_drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        per_beat(8'hF0, 8'hCC, 0);
        fork
            per_beat(8'hF0, 8'hCC, 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 0);
                    check("bp_Y_hold", 32'(y), 32'h C0);
                    check("bp_out_valid", 32'(out_valid), 1);
                end
                rdy_mode = 1;
            end
        join
        idle();
        wait_drain();
        pa[0] = 8'h01; pa[1] = 8'h04; pa[2] = 8'h08;
        pkt(5, 8'h02, 3);
        idle();
        pa[0] = 8'hFF;
        pkt(0, 8'hFF, 1);
        for (int i = 0; i < 20; i++) pa[i] = 8'hFF;
        pkt(0, 8'hFF, 20);
        idle();
        wait_drain();
        drive(8'h3C, 8'h0F, 5, 1, 0);
        drive(8'h81, 8'h00, 5, 1, 0);
        idle();
        #2 rst_n = 0;
        @(negedge clk);
        check("midpkt_rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        pa[0] = 8'h11;
        pkt(1, 8'h22, 1);
        idle();
        wait_drain();
        rdy_mode = 2;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 0) per_beat(W'($urandom), W'($urandom), 3'($urandom));
            else begin
                int n = $urandom_range(1, 20);
                for (int i = 0; i < n; i++) pa[i] = W'($urandom);
                pkt(3'($urandom), W'($urandom), n);
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
